// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, async imem read, IF/ID register, redirects and interrupt latch.
// Optional boot-vector fetch (PC loaded from imem words 0/1) when FETCH_BOOT_VECTOR_EN is defined.
module fetch_unit #(
   parameter int              PC_W       = 32,
   parameter int              INSTR_W    = 16,
   parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_0020,
   parameter logic [PC_W-1:0] INT_VECTOR = 32'h0000_0010,
   parameter logic [INSTR_W-1:0] NOP_WORD = 16'h4000
) (
   input  logic               clk,
   input  logic               reset,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   input  logic               stall_fetch,
   input  logic               pc_write_cu,
   input  logic               clear_instruction,
   input  logic               jump_taken,
   input  logic [PC_W-1:0]    jump_target,
   input  logic               pc_choose_memory,
   input  logic [PC_W-1:0]    mem_pc,
   input  logic               pc_choose_interrupt,
   input  logic               interrupt_in,
   output logic               interrupt_signal,
   output logic [PC_W-1:0]    int_return_pc,
   output logic [INSTR_W-1:0] ifid_instruction,
   output logic [PC_W-1:0]    ifid_pc,
   output logic [INSTR_W-1:0] ifid_immediate,
   output logic               ifid_valid
);

   typedef enum logic [1:0] {RUN, BOOT_HI, BOOT_LO} state_t;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] imm;
      logic               valid;
   } ifid_t;

`ifdef FETCH_BOOT_VECTOR_EN
   localparam state_t          START_STATE = BOOT_HI;
   localparam logic [PC_W-1:0] START_PC    = '0;
`else
   localparam state_t          START_STATE = RUN;
   localparam logic [PC_W-1:0] START_PC    = RESET_PC;
`endif

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   ifid_t           ifid_q, ifid_d;
   logic            pending_q, pending_d;
   logic            int_sig_q, int_sig_d;
   logic [PC_W-1:0] int_ret_q, int_ret_d;
   logic            fire;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= START_STATE;
         pc_q         <= START_PC;
         ifid_q.instr <= NOP_WORD;
         ifid_q.pc    <= '0;
         ifid_q.imm   <= '0;
         ifid_q.valid <= 1'b0;
         pending_q    <= 1'b0;
         int_sig_q    <= 1'b0;
         int_ret_q    <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ifid_q    <= ifid_d;
         pending_q <= pending_d;
         int_sig_q <= int_sig_d;
         int_ret_q <= int_ret_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ifid_d    = ifid_q;
      pending_d = pending_q;
      int_sig_d = 1'b0;
      int_ret_d = int_ret_q;
      imem_addr = pc_q;
      fire      = 1'b0;
      case (state_q)
         // Boot words are big-endian: word 0 is the upper PC half.
         BOOT_HI: begin
            imem_addr = '0;
            pc_d      = {imem_data, pc_q[INSTR_W-1:0]};
            state_d   = BOOT_LO;
         end
         BOOT_LO: begin
            imem_addr = PC_W'(1);
            pc_d      = {pc_q[PC_W-1:INSTR_W], imem_data};
            state_d   = RUN;
         end
         default: begin
            if (pc_choose_memory)                 pc_d = mem_pc;
            else if (jump_taken)                  pc_d = jump_target;
            else if (pc_choose_interrupt)         pc_d = INT_VECTOR;
            else if (stall_fetch || !pc_write_cu) pc_d = pc_q;
            else                                  pc_d = pc_q + PC_W'(1);

            // A redirect from EX/MEM kills the word fetched on the wrong path, even under stall.
            if (pc_choose_memory || jump_taken) begin
               ifid_d.instr = NOP_WORD;
               ifid_d.valid = 1'b0;
            end else if (stall_fetch) begin
               ifid_d = ifid_q;
            end else if (clear_instruction) begin
               ifid_d.imm   = imem_data;
               ifid_d.instr = NOP_WORD;
               ifid_d.valid = 1'b0;
            end else begin
               ifid_d.instr = imem_data;
               ifid_d.pc    = pc_q;
               ifid_d.valid = 1'b1;
            end

            fire = pending_q && !clear_instruction && !stall_fetch &&
                   !jump_taken && !pc_choose_memory;
         end
      endcase

      // Requests seen while the pulse is out are treated as part of the same interrupt.
      if (fire) begin
         pending_d = 1'b0;
         int_sig_d = 1'b1;
         int_ret_d = pc_q;
      end else if (interrupt_in && !int_sig_q) begin
         pending_d = 1'b1;
      end
   end

   assign interrupt_signal = int_sig_q;
   assign int_return_pc    = int_ret_q;
   assign ifid_instruction = ifid_q.instr;
   assign ifid_pc          = ifid_q.pc;
   assign ifid_immediate   = ifid_q.imm;
   assign ifid_valid       = ifid_q.valid;

endmodule
